// File: rtl/risc_pkg.sv
// Shared opcode and CCR flag-index constants for the 16-bit RISC execute stage.
package risc_pkg;

    localparam int unsigned OP_JZ   = 14;
    localparam int unsigned OP_JN   = 15;
    localparam int unsigned OP_JC   = 16;
    localparam int unsigned OP_JMP  = 17;
    localparam int unsigned OP_SETC = 18;
    localparam int unsigned OP_CLRC = 19;

    localparam int unsigned Z_IDX = 0;
    localparam int unsigned N_IDX = 1;
    localparam int unsigned C_IDX = 2;

    function automatic logic isJumpOp(input int unsigned op);
        return (op == OP_JZ) || (op == OP_JN) || (op == OP_JC) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational branch condition evaluation: decides whether a jump opcode
// is taken against the committed CCR and names the flag it consumes.
module jump_cond_eval
    import risc_pkg::*;
#(
    parameter int unsigned CCR_W = 3,
    parameter int unsigned OP_W  = 5
) (
    input  logic [OP_W-1:0]  alu_op,
    input  logic [CCR_W-1:0] ccr,
    output logic             take,
    output logic [CCR_W-1:0] clrMask
);

    always_comb begin
        take    = 1'b0;
        clrMask = '0;
        case (alu_op)
            OP_W'(OP_JZ): begin
                take           = ccr[Z_IDX];
                clrMask[Z_IDX] = 1'b1;
            end
            OP_W'(OP_JN): begin
                take           = ccr[N_IDX];
                clrMask[N_IDX] = 1'b1;
            end
            OP_W'(OP_JC): begin
                take           = ccr[C_IDX];
                clrMask[C_IDX] = 1'b1;
            end
            OP_W'(OP_JMP): take = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ccr_branch_unit.sv
// Execute-stage condition-code register, jump resolver with a one-cycle
// registered redirect, and a single-level CCR shadow for interrupt/RTI.
module ccr_branch_unit
    import risc_pkg::*;
#(
    parameter int unsigned CCR_W = 3,
    parameter int unsigned OP_W  = 5,
    parameter int unsigned PC_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             stall,
    input  logic             flush,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [CCR_W-1:0] alu_flags,
    input  logic [CCR_W-1:0] flag_we,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             int_save,
    input  logic             rti_restore,
    output logic [CCR_W-1:0] ccr,
    output logic             jump_taken,
    output logic [PC_W-1:0]  jump_pc,
    output logic             nest_err
);

    logic [CCR_W-1:0] shadow;
    logic             shadowValid;
    logic             accepted;
    logic             isJump;
    logic             take;
    logic [CCR_W-1:0] clrMask;
    logic [CCR_W-1:0] instrCcr;
    logic             redirect;
    logic             doSave;
    logic             doRestore;

    jump_cond_eval #(
        .CCR_W (CCR_W),
        .OP_W  (OP_W)
    ) u_jump_cond_eval (
        .alu_op  (alu_op),
        .ccr     (ccr),
        .take    (take),
        .clrMask (clrMask)
    );

    // The jump_taken term squashes the wrong-path instruction behind a redirect.
    assign accepted  = valid_in & ~stall & ~flush & ~jump_taken;
    assign isJump    = isJumpOp(32'(alu_op));
    assign redirect  = accepted & take;
    assign doRestore = ~stall & rti_restore;
    assign doSave    = ~stall & int_save & ~rti_restore;

    // CCR as updated by the EX instruction alone, before any RTI override.
    always_comb begin
        instrCcr = ccr;
        if (accepted) begin
            if (isJump) begin
                if (take) begin
                    instrCcr = ccr & ~clrMask;
                end
            end else if (alu_op == OP_W'(OP_SETC)) begin
                instrCcr[C_IDX] = 1'b1;
            end else if (alu_op == OP_W'(OP_CLRC)) begin
                instrCcr[C_IDX] = 1'b0;
            end else begin
                instrCcr = (flag_we & alu_flags) | (~flag_we & ccr);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccr <= '0;
        end else if (doRestore) begin
            ccr <= shadow;
        end else begin
            ccr <= instrCcr;
        end
    end

    // Shadow snapshots the next-state CCR; a save over an occupied shadow is a nesting error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            shadowValid <= 1'b0;
            nest_err    <= 1'b0;
        end else if (doRestore) begin
            shadowValid <= 1'b0;
        end else if (doSave) begin
            shadow      <= instrCcr;
            shadowValid <= 1'b1;
            if (shadowValid) begin
                nest_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jump_taken <= 1'b0;
            jump_pc    <= '0;
        end else begin
            jump_taken <= redirect;
            if (redirect) begin
                jump_pc <= jump_target;
            end
        end
    end

endmodule

// File: tb/tb_ccr_branch_unit.sv
// Directed self-checking bench for ccr_branch_unit.
module tb_ccr_branch_unit;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        stall;
    logic        flush;
    logic [4:0]  alu_op;
    logic [2:0]  alu_flags;
    logic [2:0]  flag_we;
    logic [15:0] jump_target;
    logic        int_save;
    logic        rti_restore;
    logic [2:0]  ccr;
    logic        jump_taken;
    logic [15:0] jump_pc;
    logic        nest_err;

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] JZ = 5'd14, JN = 5'd15, JC = 5'd16, JMP = 5'd17;
    localparam logic [4:0] SETC = 5'd18, CLRC = 5'd19, ADD = 5'd0;

    ccr_branch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .stall       (stall),
        .flush       (flush),
        .alu_op      (alu_op),
        .alu_flags   (alu_flags),
        .flag_we     (flag_we),
        .jump_target (jump_target),
        .int_save    (int_save),
        .rti_restore (rti_restore),
        .ccr         (ccr),
        .jump_taken  (jump_taken),
        .jump_pc     (jump_pc),
        .nest_err    (nest_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] we,
                         input logic [2:0] fl, input logic [15:0] tgt);
        valid_in    = v;
        alu_op      = op;
        flag_we     = we;
        alu_flags   = fl;
        jump_target = tgt;
        stall       = 1'b0;
        flush       = 1'b0;
        int_save    = 1'b0;
        rti_restore = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, ADD, 3'b000, 3'b000, 16'h0000);
        rst = 1'b1;
        #12;
        check("rst_ccr", 32'(ccr), 32'h0);
        check("rst_jt", 32'(jump_taken), 32'h0);
        check("rst_pc", 32'(jump_pc), 32'h0);
        check("rst_nest", 32'(nest_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Flag update under full mask
        drive(1'b1, ADD, 3'b111, 3'b101, 16'h0000);
        tick();
        check("upd_ccr", 32'(ccr), 32'h5);
        check("upd_jt", 32'(jump_taken), 32'h0);

        // Partial mask keeps unmasked bits
        drive(1'b1, ADD, 3'b011, 3'b001, 16'h0000);
        tick();
        check("mask_ccr", 32'(ccr), 32'h5);
        drive(1'b1, ADD, 3'b111, 3'b001, 16'h0000);
        tick();
        check("set_z", 32'(ccr), 32'h1);

        // JZ taken, then a JMP in the pulse cycle is squashed
        drive(1'b1, JZ, 3'b000, 3'b000, 16'h00A4);
        tick();
        check("jz_jt", 32'(jump_taken), 32'h1);
        check("jz_pc", 32'(jump_pc), 32'h00A4);
        check("jz_ccr", 32'(ccr), 32'h0);
        drive(1'b1, JMP, 3'b000, 3'b000, 16'h1234);
        tick();
        check("squash_jt", 32'(jump_taken), 32'h0);
        check("squash_pc", 32'(jump_pc), 32'h00A4);

        // JC not taken, SETC, JC taken
        drive(1'b1, JC, 3'b000, 3'b000, 16'h0033);
        tick();
        check("jc_nt_jt", 32'(jump_taken), 32'h0);
        check("jc_nt_ccr", 32'(ccr), 32'h0);
        drive(1'b1, SETC, 3'b000, 3'b000, 16'h0000);
        tick();
        check("setc_ccr", 32'(ccr), 32'h4);
        drive(1'b1, JC, 3'b000, 3'b000, 16'h0055);
        tick();
        check("jc_jt", 32'(jump_taken), 32'h1);
        check("jc_pc", 32'(jump_pc), 32'h0055);
        check("jc_ccr", 32'(ccr), 32'h0);
        drive(1'b0, ADD, 3'b000, 3'b000, 16'h0000);
        tick();
        check("jc_pulse_end", 32'(jump_taken), 32'h0);

        // Shadow save / CLRC / restore
        drive(1'b1, ADD, 3'b111, 3'b110, 16'h0000);
        tick();
        check("ccr_110", 32'(ccr), 32'h6);
        drive(1'b0, ADD, 3'b000, 3'b000, 16'h0000);
        int_save = 1'b1;
        tick();
        drive(1'b1, CLRC, 3'b000, 3'b000, 16'h0000);
        tick();
        check("clrc_ccr", 32'(ccr), 32'h2);
        drive(1'b0, ADD, 3'b000, 3'b000, 16'h0000);
        rti_restore = 1'b1;
        tick();
        check("rti_ccr", 32'(ccr), 32'h6);
        check("rti_nest", 32'(nest_err), 32'h0);

        // Save captures next-state CCR; restore overrides a same-cycle update
        drive(1'b1, CLRC, 3'b000, 3'b000, 16'h0000);
        int_save = 1'b1;
        tick();
        check("save_clrc_ccr", 32'(ccr), 32'h2);
        drive(1'b1, SETC, 3'b000, 3'b000, 16'h0000);
        tick();
        check("setc2_ccr", 32'(ccr), 32'h6);
        drive(1'b1, ADD, 3'b111, 3'b001, 16'h0000);
        rti_restore = 1'b1;
        tick();
        check("rti_override", 32'(ccr), 32'h2);
        check("rti2_nest", 32'(nest_err), 32'h0);

        // Nested save sets sticky error
        drive(1'b0, ADD, 3'b000, 3'b000, 16'h0000);
        int_save = 1'b1;
        tick();
        check("save1_nest", 32'(nest_err), 32'h0);
        tick();
        check("save2_nest", 32'(nest_err), 32'h1);
        drive(1'b0, ADD, 3'b000, 3'b000, 16'h0000);
        rti_restore = 1'b1;
        tick();
        check("nest_sticky", 32'(nest_err), 32'h1);
        check("rti3_ccr", 32'(ccr), 32'h2);

        // Stall freezes a taken JN; release gives the pulse
        drive(1'b1, JN, 3'b000, 3'b000, 16'h0077);
        stall = 1'b1;
        tick();
        check("stall_jt", 32'(jump_taken), 32'h0);
        check("stall_ccr", 32'(ccr), 32'h2);
        check("stall_pc", 32'(jump_pc), 32'h0055);
        stall = 1'b0;
        tick();
        check("jn_jt", 32'(jump_taken), 32'h1);
        check("jn_pc", 32'(jump_pc), 32'h0077);
        check("jn_ccr", 32'(ccr), 32'h0);
        drive(1'b0, ADD, 3'b000, 3'b000, 16'h0000);
        stall = 1'b1;
        tick();
        check("stall_pulse_fall", 32'(jump_taken), 32'h0);

        // Flush blocks flag update and jumps
        drive(1'b1, ADD, 3'b111, 3'b111, 16'h0000);
        flush = 1'b1;
        tick();
        check("flush_ccr", 32'(ccr), 32'h0);
        drive(1'b1, JMP, 3'b000, 3'b000, 16'h0088);
        flush = 1'b1;
        tick();
        check("flush_jmp", 32'(jump_taken), 32'h0);

        // Asynchronous reset during a pulse
        drive(1'b1, ADD, 3'b111, 3'b010, 16'h0000);
        tick();
        drive(1'b1, JMP, 3'b000, 3'b000, 16'h0099);
        tick();
        check("jmp_jt", 32'(jump_taken), 32'h1);
        check("jmp_pc", 32'(jump_pc), 32'h0099);
        check("jmp_ccr", 32'(ccr), 32'h2);
        drive(1'b0, ADD, 3'b000, 3'b000, 16'h0000);
        #2;
        rst = 1'b1;
        #1;
        check("arst_jt", 32'(jump_taken), 32'h0);
        check("arst_pc", 32'(jump_pc), 32'h0);
        check("arst_ccr", 32'(ccr), 32'h0);
        check("arst_nest", 32'(nest_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
